// File: rtl/snvs_lp_zmk_ctrl.sv
// -----------------------------------------------------------------------------
// snvs_lp_zmk_ctrl
//
// Zeroizable master key (ZMK) store for the SNVS LP domain. The key is held as
// NUM_WORDS words of DATA_WIDTH bits. Each word also has a stored parity bit.
// The key can be loaded in three ways: per-word software writes, a sequential
// hardware-programming (HWP) load with a valid/ready handshake, and a
// sequential hardware zeroize. A sticky write lock blocks software writes and
// entry into HWP loading.
//
// Ports
//   ipg_clk        system clock
//   zmk_reset_b    asynchronous active-low reset
//   zmk_zeroize    zeroize request (acted on in IDLE and mid-HWP load)
//   write_lpzmk    per-word software write strobes
//   lp_wdata       software write data
//   zmk_wlock      sets the sticky write lock
//   hwp_mode       hardware-programming mode select
//   hwp_valid      HWP word valid
//   hwp_data       HWP word data
//   hwp_ready      HWP word accept (high only while loading)
//   lpzmk_reg      key value, word i at [DATA_WIDTH*i +: DATA_WIDTH]
//   zmk_busy       FSM is not IDLE
//   zmk_zero_done  one-cycle pulse on the first IDLE cycle after zeroize
//   zmk_locked     sticky write lock status
//   zmk_valid      every word written since the last zeroize or reset
//   zmk_par_err    sticky parity mismatch flag
// -----------------------------------------------------------------------------
module snvs_lp_zmk_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 8,
  parameter int IDX_W      = 3
) (
  input  logic                            ipg_clk,
  input  logic                            zmk_reset_b,
  input  logic                            zmk_zeroize,
  input  logic [NUM_WORDS-1:0]            write_lpzmk,
  input  logic [DATA_WIDTH-1:0]           lp_wdata,
  input  logic                            zmk_wlock,
  input  logic                            hwp_mode,
  input  logic                            hwp_valid,
  input  logic [DATA_WIDTH-1:0]           hwp_data,
  output logic                            hwp_ready,
  output logic [NUM_WORDS*DATA_WIDTH-1:0] lpzmk_reg,
  output logic                            zmk_busy,
  output logic                            zmk_zero_done,
  output logic                            zmk_locked,
  output logic                            zmk_valid,
  output logic                            zmk_par_err
);

  localparam int               KEY_W    = NUM_WORDS * DATA_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HWP_LOAD = 2'd1,
    ZEROIZE  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [KEY_W-1:0]       key_q, key_d;
  logic [NUM_WORDS-1:0]   par_q, par_d;
  logic [NUM_WORDS-1:0]   written_q, written_d;
  logic                   locked_q, locked_d;
  logic                   par_err_q, par_err_d;
  logic                   zero_done_q, zero_done_d;
  logic [NUM_WORDS-1:0]   mismatch;

  // Word contents and stored parity always change on the same edge, so a
  // mismatch here can only come from corruption of the key storage.
  always_comb begin
    mismatch = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      mismatch[i] = (^key_q[DATA_WIDTH*i +: DATA_WIDTH]) != par_q[i];
    end
  end

  always_comb begin
    // NOTE: every variable assigned in this block gets a default first, so no
    // path through the case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    key_d       = key_q;
    par_d       = par_q;
    written_d   = written_q;
    zero_done_d = 1'b0;
    hwp_ready   = 1'b0;
    // A write in the same cycle as zmk_wlock still sees the old lock value.
    locked_d    = locked_q | zmk_wlock;
    par_err_d   = par_err_q | (|mismatch);

    unique case (state_q)
      IDLE: begin
        if (zmk_zeroize) begin
          state_d = ZEROIZE;
          idx_d   = '0;
        end else if (hwp_mode && !locked_q) begin
          state_d = HWP_LOAD;
          idx_d   = '0;
        end else if (!hwp_mode && !locked_q) begin
          for (int i = 0; i < NUM_WORDS; i++) begin
            if (write_lpzmk[i]) begin
              key_d[DATA_WIDTH*i +: DATA_WIDTH] = lp_wdata;
              par_d[i]     = ^lp_wdata;
              written_d[i] = 1'b1;
            end
          end
        end
      end

      HWP_LOAD: begin
        hwp_ready = 1'b1;
        // Abort discards the partial key; a word offered this cycle is dropped.
        if (zmk_zeroize || !hwp_mode) begin
          state_d = ZEROIZE;
          idx_d   = '0;
        end else if (hwp_valid) begin
          for (int i = 0; i < NUM_WORDS; i++) begin
            if (idx_q == IDX_W'(i)) begin
              key_d[DATA_WIDTH*i +: DATA_WIDTH] = hwp_data;
              par_d[i]     = ^hwp_data;
              written_d[i] = 1'b1;
            end
          end
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      ZEROIZE: begin
        for (int i = 0; i < NUM_WORDS; i++) begin
          if (idx_q == IDX_W'(i)) begin
            key_d[DATA_WIDTH*i +: DATA_WIDTH] = '0;
            par_d[i]     = 1'b0;
            written_d[i] = 1'b0;
          end
        end
        // Exit on the last word so idx never runs past NUM_WORDS-1.
        if (idx_q == LAST_IDX) begin
          state_d     = IDLE;
          idx_d       = '0;
          zero_done_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge ipg_clk or negedge zmk_reset_b) begin
    if (!zmk_reset_b) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      // NOTE: the key storage is reset along with the control state; a key
      // must never come up holding stale or random contents.
      key_q       <= '0;
      par_q       <= '0;
      written_q   <= '0;
      locked_q    <= 1'b0;
      par_err_q   <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state_q     <= state_d;
      idx_q       <= idx_d;
      key_q       <= key_d;
      par_q       <= par_d;
      written_q   <= written_d;
      locked_q    <= locked_d;
      par_err_q   <= par_err_d;
      zero_done_q <= zero_done_d;
    end
  end

  assign lpzmk_reg     = key_q;
  assign zmk_busy      = (state_q != IDLE);
  assign zmk_zero_done = zero_done_q;
  assign zmk_locked    = locked_q;
  assign zmk_valid     = &written_q;
  assign zmk_par_err   = par_err_q;

endmodule

// File: tb/tb_snvs_lp_zmk_ctrl.sv
// -----------------------------------------------------------------------------
// tb_snvs_lp_zmk_ctrl
//
// Directed bench for snvs_lp_zmk_ctrl: a vector table for software writes and
// the lock, plus hand-written sequences for zeroize, HWP load/abort, parity
// corruption and reset during zeroize. Inputs change and outputs are sampled
// on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_snvs_lp_zmk_ctrl;

  localparam int DW    = 32;
  localparam int NW    = 8;
  localparam int IW    = 3;
  localparam int KEY_W = NW * DW;

  logic              ipg_clk;
  logic              zmk_reset_b;
  logic              zmk_zeroize;
  logic [NW-1:0]     write_lpzmk;
  logic [DW-1:0]     lp_wdata;
  logic              zmk_wlock;
  logic              hwp_mode;
  logic              hwp_valid;
  logic [DW-1:0]     hwp_data;
  logic              hwp_ready;
  logic [KEY_W-1:0]  lpzmk_reg;
  logic              zmk_busy;
  logic              zmk_zero_done;
  logic              zmk_locked;
  logic              zmk_valid;
  logic              zmk_par_err;

  snvs_lp_zmk_ctrl #(
    .DATA_WIDTH (DW),
    .NUM_WORDS  (NW),
    .IDX_W      (IW)
  ) dut (
    .ipg_clk       (ipg_clk),
    .zmk_reset_b   (zmk_reset_b),
    .zmk_zeroize   (zmk_zeroize),
    .write_lpzmk   (write_lpzmk),
    .lp_wdata      (lp_wdata),
    .zmk_wlock     (zmk_wlock),
    .hwp_mode      (hwp_mode),
    .hwp_valid     (hwp_valid),
    .hwp_data      (hwp_data),
    .hwp_ready     (hwp_ready),
    .lpzmk_reg     (lpzmk_reg),
    .zmk_busy      (zmk_busy),
    .zmk_zero_done (zmk_zero_done),
    .zmk_locked    (zmk_locked),
    .zmk_valid     (zmk_valid),
    .zmk_par_err   (zmk_par_err)
  );

  initial ipg_clk = 1'b0;
  always #5 ipg_clk = ~ipg_clk;

  int total = 0;
  int bad   = 0;

  logic [KEY_W-1:0] exp_key;
  logic [KEY_W-1:0] forced_key;

  typedef struct {
    logic [NW-1:0] wr;
    logic [DW-1:0] data;
    logic          wlock;
    logic          hwp;
    logic          exp_valid;
    logic          exp_locked;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [KEY_W-1:0] act,
                       input logic [KEY_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check(name, KEY_W'(act), KEY_W'(exp));
  endtask

  function automatic logic [DW-1:0] word_of(input logic [KEY_W-1:0] k, input int i);
    return k[DW*i +: DW];
  endfunction

  task automatic tick();
    @(posedge ipg_clk);
    @(negedge ipg_clk);
  endtask

  task automatic idle_inputs();
    zmk_zeroize = 1'b0;
    write_lpzmk = '0;
    lp_wdata    = '0;
    zmk_wlock   = 1'b0;
    hwp_mode    = 1'b0;
    hwp_valid   = 1'b0;
    hwp_data    = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " key"}, lpzmk_reg, '0);
    check_bit({tag, " busy"}, zmk_busy, 1'b0);
    check_bit({tag, " zero_done"}, zmk_zero_done, 1'b0);
    check_bit({tag, " locked"}, zmk_locked, 1'b0);
    check_bit({tag, " valid"}, zmk_valid, 1'b0);
    check_bit({tag, " par_err"}, zmk_par_err, 1'b0);
    check_bit({tag, " hwp_ready"}, hwp_ready, 1'b0);
  endtask

  task automatic do_reset();
    idle_inputs();
    zmk_reset_b = 1'b0;
    #1;
    check_all_zero("reset");
    tick();
    zmk_reset_b = 1'b1;
    exp_key = '0;
  endtask

  // Counts cycles until busy drops, bounded so a stuck FSM still ends the run.
  task automatic wait_idle(input string name, input int exp_cycles);
    int n = 0;
    while (zmk_busy && n < 40) begin
      tick();
      n++;
    end
    check(name, KEY_W'(n), KEY_W'(exp_cycles));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{wr: 8'h05, data: 32'hDEADBEEF, wlock: 1'b0, hwp: 1'b0, exp_valid: 1'b0, exp_locked: 1'b0};
    vecs[1] = '{wr: 8'hFA, data: 32'hDEADBEEF, wlock: 1'b0, hwp: 1'b0, exp_valid: 1'b1, exp_locked: 1'b0};
    vecs[2] = '{wr: 8'h01, data: 32'h00000001, wlock: 1'b0, hwp: 1'b0, exp_valid: 1'b1, exp_locked: 1'b0};
    vecs[3] = '{wr: 8'h00, data: 32'hCAFEF00D, wlock: 1'b0, hwp: 1'b0, exp_valid: 1'b1, exp_locked: 1'b0};
    vecs[4] = '{wr: 8'h02, data: 32'h12345678, wlock: 1'b1, hwp: 1'b0, exp_valid: 1'b1, exp_locked: 1'b1};
    vecs[5] = '{wr: 8'hFF, data: 32'h00000000, wlock: 1'b0, hwp: 1'b0, exp_valid: 1'b1, exp_locked: 1'b1};
    vecs[6] = '{wr: 8'h04, data: 32'h55555555, wlock: 1'b0, hwp: 1'b1, exp_valid: 1'b1, exp_locked: 1'b1};

    // ---------------- software writes and lock (table) ----------------
    do_reset();
    for (int v = 0; v < 7; v++) begin
      logic locked_before;
      locked_before = zmk_locked;
      write_lpzmk = vecs[v].wr;
      lp_wdata    = vecs[v].data;
      zmk_wlock   = vecs[v].wlock;
      hwp_mode    = vecs[v].hwp;
      if (!vecs[v].hwp && !(v >= 5)) begin
        for (int i = 0; i < NW; i++)
          if (vecs[v].wr[i]) exp_key[DW*i +: DW] = vecs[v].data;
      end
      tick();
      check($sformatf("vec%0d key", v), lpzmk_reg, exp_key);
      check_bit($sformatf("vec%0d valid", v), zmk_valid, vecs[v].exp_valid);
      check_bit($sformatf("vec%0d locked", v), zmk_locked, vecs[v].exp_locked);
      check_bit($sformatf("vec%0d busy", v), zmk_busy, 1'b0);
      if (v == 4) check_bit("lock same-cycle write old lock", locked_before, 1'b0);
    end
    check("word1 written with lock", KEY_W'(word_of(lpzmk_reg, 1)), KEY_W'(32'h12345678));
    idle_inputs();

    // Zeroize still works while locked, and the lock survives it.
    zmk_zeroize = 1'b1;
    tick();
    zmk_zeroize = 1'b0;
    wait_idle("locked zeroize cycles", NW);
    check("locked zeroize key", lpzmk_reg, '0);
    check_bit("locked zeroize locked", zmk_locked, 1'b1);
    check_bit("locked zeroize valid", zmk_valid, 1'b0);

    // ---------------- zeroize sequence ----------------
    do_reset();
    write_lpzmk = '1;
    lp_wdata    = 32'hA5A5A5A5;
    tick();
    write_lpzmk = '0;
    check_bit("full load valid", zmk_valid, 1'b1);
    zmk_zeroize = 1'b1;
    tick();
    for (int c = 0; c < NW; c++) begin
      // A repeat request partway through must not restart the sweep.
      zmk_zeroize = (c == 3);
      check_bit($sformatf("zero c%0d busy", c), zmk_busy, 1'b1);
      check_bit($sformatf("zero c%0d done", c), zmk_zero_done, 1'b0);
      check($sformatf("zero c%0d word%0d kept", c, c),
            KEY_W'(word_of(lpzmk_reg, c)), KEY_W'(32'hA5A5A5A5));
      if (c > 0)
        check($sformatf("zero c%0d word%0d cleared", c, c - 1),
              KEY_W'(word_of(lpzmk_reg, c - 1)), '0);
      tick();
    end
    zmk_zeroize = 1'b0;
    check_bit("zero end busy", zmk_busy, 1'b0);
    check_bit("zero end done pulse", zmk_zero_done, 1'b1);
    check_bit("zero end valid", zmk_valid, 1'b0);
    check("zero end key", lpzmk_reg, '0);
    tick();
    check_bit("zero done one cycle", zmk_zero_done, 1'b0);
    check_bit("zero stays idle", zmk_busy, 1'b0);

    // Zeroize and a write in the same IDLE cycle: the write is dropped.
    zmk_zeroize = 1'b1;
    write_lpzmk = 8'h01;
    lp_wdata    = 32'h11111111;
    tick();
    idle_inputs();
    check("zero+write word0", KEY_W'(word_of(lpzmk_reg, 0)), '0);
    check_bit("zero+write busy", zmk_busy, 1'b1);
    wait_idle("zero+write cycles", NW);
    check_bit("zero+write valid", zmk_valid, 1'b0);

    // ---------------- HWP load with stalls ----------------
    hwp_mode = 1'b1;
    tick();
    check_bit("hwp enter busy", zmk_busy, 1'b1);
    check_bit("hwp enter ready", hwp_ready, 1'b1);
    exp_key = '0;
    for (int i = 0; i < NW; i++) begin
      hwp_valid = 1'b1;
      hwp_data  = DW'(i + 1);
      exp_key[DW*i +: DW] = DW'(i + 1);
      tick();
      check($sformatf("hwp word%0d", i), KEY_W'(word_of(lpzmk_reg, i)), KEY_W'(i + 1));
      if (i < NW - 1) begin
        hwp_valid = 1'b0;
        hwp_data  = 32'hFFFFFFFF;
        tick();
        check($sformatf("hwp stall word%0d", i + 1), KEY_W'(word_of(lpzmk_reg, i + 1)), '0);
        check_bit($sformatf("hwp stall ready%0d", i), hwp_ready, 1'b1);
      end
    end
    hwp_mode  = 1'b0;
    hwp_valid = 1'b0;
    check_bit("hwp done busy", zmk_busy, 1'b0);
    check_bit("hwp done ready", hwp_ready, 1'b0);
    check_bit("hwp done valid", zmk_valid, 1'b1);
    check("hwp done key", lpzmk_reg, exp_key);
    tick();
    check_bit("hwp idle after", zmk_busy, 1'b0);

    // HWP aborted after three words by dropping hwp_mode.
    hwp_mode = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      hwp_valid = 1'b1;
      hwp_data  = DW'(32'h100 + i);
      tick();
    end
    hwp_mode = 1'b0;
    hwp_data = 32'h0000AAAA;
    tick();
    hwp_valid = 1'b0;
    check_bit("abort busy", zmk_busy, 1'b1);
    check_bit("abort ready", hwp_ready, 1'b0);
    check("abort word0 partial", KEY_W'(word_of(lpzmk_reg, 0)), KEY_W'(32'h100));
    check("abort word3 not taken", KEY_W'(word_of(lpzmk_reg, 3)), KEY_W'(4));
    wait_idle("abort zeroize cycles", NW);
    check("abort key cleared", lpzmk_reg, '0);
    check_bit("abort valid", zmk_valid, 1'b0);
    check_bit("abort done pulse", zmk_zero_done, 1'b1);

    // ---------------- parity ----------------
    check_bit("parity clean so far", zmk_par_err, 1'b0);
    write_lpzmk = '1;
    lp_wdata    = 32'h0F0F0F0F;
    tick();
    idle_inputs();
    exp_key = {NW{32'h0F0F0F0F}};
    check("parity base key", lpzmk_reg, exp_key);
    check_bit("parity clean after write", zmk_par_err, 1'b0);
    forced_key = exp_key;
    forced_key[3*DW + 5] = ~forced_key[3*DW + 5];
    force dut.key_q = forced_key;
    tick();
    release dut.key_q;
    check_bit("parity err set", zmk_par_err, 1'b1);
    tick();
    check_bit("parity err sticky", zmk_par_err, 1'b1);
    zmk_zeroize = 1'b1;
    tick();
    zmk_zeroize = 1'b0;
    wait_idle("parity zeroize cycles", NW);
    check_bit("parity err after zeroize", zmk_par_err, 1'b1);
    check("parity zeroize key", lpzmk_reg, '0);

    // ---------------- reset during zeroize ----------------
    do_reset();
    write_lpzmk = '1;
    lp_wdata    = 32'h77777777;
    zmk_wlock   = 1'b1;
    tick();
    idle_inputs();
    check_bit("mid reset locked", zmk_locked, 1'b1);
    zmk_zeroize = 1'b1;
    tick();
    zmk_zeroize = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    check("mid reset word3 cleared", KEY_W'(word_of(lpzmk_reg, 3)), '0);
    check("mid reset word4 kept", KEY_W'(word_of(lpzmk_reg, 4)), KEY_W'(32'h77777777));
    check_bit("mid reset busy", zmk_busy, 1'b1);
    zmk_reset_b = 1'b0;
    #1;
    check_all_zero("mid zeroize reset");
    tick();
    zmk_reset_b = 1'b1;
    tick();
    check_bit("post reset idle", zmk_busy, 1'b0);
    write_lpzmk = 8'h01;
    lp_wdata    = 32'h00000009;
    tick();
    idle_inputs();
    check("post reset write", KEY_W'(word_of(lpzmk_reg, 0)), KEY_W'(9));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snvs_lp_zmk_ctrl.md
Name: snvs_lp_zmk_ctrl

Overview:
Next-generation zeroizable master key (ZMK) store for the SNVS LP domain. Key width is parametrised as NUM_WORDS words of DATA_WIDTH bits. Adds the following over a plain key register:
- sequential hardware zeroize with busy/done status
- hardware-programming (HWP) load path with a valid/ready handshake
- sticky write lock
- per-word parity integrity checking

The block sits between the LP register interface and the key consumers.

Parameters:
DATA_WIDTH, 32, bits per key word (matches LP write data width)
NUM_WORDS, 8, number of key words; key width = NUM_WORDS*DATA_WIDTH (default 256)
IDX_W, 3, word index width; must satisfy 2**IDX_W >= NUM_WORDS

Ports:
ipg_clk  in  1  system clock
zmk_reset_b  in  1  asynchronous active-low reset
zmk_zeroize  in  1  zeroize request, sampled in IDLE
write_lpzmk  in  NUM_WORDS  per-word software write strobes
lp_wdata  in  DATA_WIDTH  LP write data
zmk_wlock  in  1  sets sticky write lock
hwp_mode  in  1  hardware-programming mode select
hwp_valid  in  1  HWP word valid
hwp_data  in  DATA_WIDTH  HWP word data
hwp_ready  out  1  HWP word accept
lpzmk_reg  out  NUM_WORDS*DATA_WIDTH  key value; word i occupies bits [DATA_WIDTH*i +: DATA_WIDTH]
zmk_busy  out  1  FSM not in IDLE
zmk_zero_done  out  1  one-cycle pulse when zeroize completes
zmk_locked  out  1  sticky write lock status
zmk_valid  out  1  every word written since the last zeroize or reset
zmk_par_err  out  1  sticky parity mismatch flag

Behaviour:
- Reset (async assert, sync deassert via ipg_clk): key, parity bits, written mask, lock, par_err, index = 0; FSM = IDLE. All outputs reset to 0.
- State register: 2-bit FSM with states IDLE, HWP_LOAD, ZEROIZE, plus an IDX_W-bit index register.
- IDLE transitions, in priority order:
  - zmk_zeroize=1 -> ZEROIZE, idx=0.
  - else hwp_mode=1 and !locked -> HWP_LOAD, idx=0.
  - else software writes apply.
- Software write (IDLE only; requires !locked and !hwp_mode):
  - Each word i with write_lpzmk[i]=1 loads lp_wdata at the next edge.
  - That word's stored parity is set to ^lp_wdata and written[i] is set.
  - Multiple strobes may be active in the same cycle.
- Dropped writes: software writes in any non-IDLE state, while locked, while hwp_mode=1, or in the same cycle as an accepted zeroize request are dropped silently.
- HWP_LOAD:
  - hwp_ready=1 in this state only.
  - On hwp_valid & hwp_ready: word[idx]=hwp_data, parity and written bit updated, idx++.
  - Accepting word NUM_WORDS-1 -> IDLE.
  - zmk_zeroize=1 or hwp_mode=0 mid-load -> ZEROIZE with idx=0; the partial key is discarded. Any word offered in that same cycle is not accepted.
- ZEROIZE:
  - Each cycle clears word[idx], its parity bit and written[idx]; idx++. Takes exactly NUM_WORDS cycles.
  - The cycle that clears word NUM_WORDS-1 -> IDLE. zmk_zero_done pulses high for the first IDLE cycle.
  - Further zeroize requests during ZEROIZE are ignored.
- Lock:
  - zmk_wlock=1 sets locked at the next edge; a software write in the same cycle is still accepted.
  - Cleared only by reset.
  - Lock does not block zeroize and is not cleared by zeroize.
  - Lock blocks entry to HWP_LOAD but does not abort a load already in progress.
- zmk_busy = (state != IDLE), registered state decode. zmk_valid = &written.
- Parity:
  - Every cycle, for each word, ^word != stored parity -> zmk_par_err set at the next edge.
  - Sticky; cleared only by reset.
  - The check must not false-fire during writes or zeroize, because word and parity update on the same edge.
- Index wrap: idx never exceeds NUM_WORDS-1. The FSM exits on the last word, so a non-power-of-two NUM_WORDS is legal.
- Reset asserted mid-HWP or mid-zeroize: immediate return to the reset state.

Test Plan:
1. SW write: write_lpzmk=8'h05, lp_wdata=32'hDEADBEEF -> words 0 and 2 = DEADBEEF next cycle, other words 0, zmk_valid=0; then write 8'hFA -> zmk_valid=1.
2. Zeroize: load all words 32'hA5A5A5A5, pulse zmk_zeroize -> zmk_busy=1 for 8 cycles, word i reads 0 from cycle i+1, zmk_zero_done pulses once, zmk_valid=0; zeroize plus write in the same IDLE cycle -> write dropped.
3. HWP: hwp_mode=1, hwp_data=i+1 with hwp_valid stalled (toggle 1/0) -> 8 accepts, words = 1..8, back to IDLE, zmk_valid=1; drop hwp_mode after 3 words -> zeroize runs, all words 0.
4. Lock: zmk_wlock and write word 1 = 32'h12345678 in the same cycle -> write lands, locked=1; later writes and hwp_mode ignored; zmk_zeroize still clears the key and zmk_locked stays 1.
5. Parity: force bit 5 of word 3 flipped for one cycle -> zmk_par_err=1 and stays 1 after release and after zeroize; a normal write/zeroize sequence never sets it.
6. Reset in the middle of ZEROIZE at idx=4 -> all outputs 0, state IDLE; NUM_WORDS=5 build passes scenarios 2 and 3 with 5-cycle zeroize.
